// File: rtl/func_unit_sched.sv
// Round-robin scheduler sharing one offset/threshold function unit among NUM_REQ requesters.
// One grant per cycle into a single-entry result buffer, with a run/drain/stop control FSM.
module func_unit_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned OFFSET  = 5,
  parameter int unsigned THRESH  = 50,
  parameter int unsigned BIAS    = 10,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DW-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [DW-1:0]              rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  input  logic                       rsp_ready,
  output logic                       stopped,
  output logic [CNT_W-1:0]           txn_count
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  localparam logic [1:0] StStopped = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StDrain   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0] txn_q, txn_d;

  logic [DW-1:0]    lane [NUM_REQ];
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             slot_free;
  logic             can_accept;
  logic             accept;
  logic             pop;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign lane[gi] = req_data[gi*DW +: DW];
  end

  // Sum wraps modulo 2^DW; the threshold compare is done at full width.
  function automatic logic [DW-1:0] f_op(input logic [DW-1:0] x);
    logic [DW-1:0] sum;
    sum = x + DW'(OFFSET);
    if (32'(x) > THRESH) begin
      sum = sum + DW'(BIAS);
    end
    return sum;
  endfunction

  assign slot_free  = !rsp_valid_q || rsp_ready;
  assign can_accept = (state_q == StRun) && slot_free;
  assign pop        = rsp_valid_q && rsp_ready;

  // Search upward from ptr, wrapping at NUM_REQ rather than at 2^IDW.
  always_comb begin
    int unsigned    idx;
    logic [IDW-1:0] idx_n;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_n = IDW'(idx);
      if (!grant_found && req_valid[idx_n]) begin
        grant_found = 1'b1;
        grant_idx   = idx_n;
      end
    end
  end

  assign accept = can_accept && grant_found;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;
    txn_d       = txn_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = f_op(lane[grant_idx]);
      rsp_id_d    = grant_idx;
      ptr_d       = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
      txn_d       = txn_q + CNT_W'(1);
    end else if (pop) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StStopped: begin
        if (enable) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!enable) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Re-enable wins over drain completion.
        if (enable) begin
          state_d = StRun;
        end else if (!rsp_valid_q || pop) begin
          state_d = StStopped;
        end
      end
      default: state_d = StStopped;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StStopped;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      txn_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      txn_q       <= txn_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign txn_count = txn_q;
  assign stopped   = (state_q == StStopped);

endmodule

// File: tb/tb_func_unit_sched.sv
// Bench for func_unit_sched: directed vector table, async-reset sequence, and random
// stimulus against a behavioural reference model.
module tb_func_unit_sched;

  localparam int N      = 4;
  localparam int THRESH = 50;
  localparam int OFFSET = 5;
  localparam int BIAS   = 10;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ready;
  logic        stopped;
  logic [15:0] txn_count;

  func_unit_sched dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .stopped   (stopped),
    .txn_count (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic        rr;
    logic [3:0]  xr;
    logic        xv;
    logic [7:0]  xd;
    logic [1:0]  xid;
    logic [15:0] xc;
    logic        xs;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic [3:0] rv, input logic [31:0] rd,
                              input logic rr, input logic [3:0] xr, input logic xv,
                              input logic [7:0] xd, input logic [1:0] xid,
                              input logic [15:0] xc, input logic xs);
    vec_t v;
    v.en = en; v.rv = rv; v.rd = rd; v.rr = rr;
    v.xr = xr; v.xv = xv; v.xd = xd; v.xid = xid; v.xc = xc; v.xs = xs;
    return v;
  endfunction

  // Reference model: the specification's rules in plain arithmetic.
  localparam int MStop  = 0;
  localparam int MRun   = 1;
  localparam int MDrain = 2;

  int          m_state;
  bit          m_valid;
  int          m_data;
  int          m_id;
  int          m_ptr;
  int          m_cnt;

  function automatic int f_ref(input int x);
    int s;
    s = (x > THRESH) ? x + BIAS + OFFSET : x + OFFSET;
    return s % 256;
  endfunction

  function automatic int model_grant(input logic [3:0] rv);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (rv[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_state = MStop; m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit en, input logic [3:0] rv, input logic [31:0] rd,
                            input bit rr);
    int  g;
    bit  acc;
    bit  pop;
    bit  old_valid;
    g         = model_grant(rv);
    acc       = (m_state == MRun) && (!m_valid || rr) && (g >= 0);
    pop       = m_valid && rr;
    old_valid = m_valid;
    if (acc) begin
      m_valid = 1;
      m_data  = f_ref(int'(rd[g*8 +: 8]));
      m_id    = g;
      m_ptr   = (g + 1) % N;
      m_cnt   = (m_cnt + 1) % 65536;
    end else if (pop) begin
      m_valid = 0;
    end
    case (m_state)
      MStop:   if (en) m_state = MRun;
      MRun:    if (!en) m_state = MDrain;
      default: begin
        if (en) m_state = MRun;
        else if (!old_valid || pop) m_state = MStop;
      end
    endcase
  endtask

  vec_t tbl[22];

  initial begin
    reset = 1'b1; enable = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b1;

    tbl[0]  = mk(1, 4'h1, 32'h00000014, 1, 4'h0, 0, 0,  0, 0,  0);
    tbl[1]  = mk(1, 4'h1, 32'h00000014, 1, 4'h1, 1, 25, 0, 1,  0);
    tbl[2]  = mk(1, 4'h2, 32'h00003200, 1, 4'h2, 1, 55, 1, 2,  0);
    tbl[3]  = mk(1, 4'h2, 32'h00003300, 1, 4'h2, 1, 66, 1, 3,  0);
    tbl[4]  = mk(1, 4'h2, 32'h0000FA00, 1, 4'h2, 1, 9,  1, 4,  0);
    tbl[5]  = mk(1, 4'hF, 32'h04030201, 1, 4'h4, 1, 8,  2, 5,  0);
    tbl[6]  = mk(1, 4'hF, 32'h04030201, 1, 4'h8, 1, 9,  3, 6,  0);
    tbl[7]  = mk(1, 4'hF, 32'h04030201, 1, 4'h1, 1, 6,  0, 7,  0);
    tbl[8]  = mk(1, 4'hF, 32'h04030201, 1, 4'h2, 1, 7,  1, 8,  0);
    tbl[9]  = mk(1, 4'hF, 32'h04030201, 1, 4'h4, 1, 8,  2, 9,  0);
    tbl[10] = mk(1, 4'hF, 32'h04030201, 1, 4'h8, 1, 9,  3, 10, 0);
    tbl[11] = mk(1, 4'hC, 32'h08070000, 1, 4'h4, 1, 12, 2, 11, 0);
    tbl[12] = mk(1, 4'hC, 32'h08070000, 0, 4'h0, 1, 12, 2, 11, 0);
    tbl[13] = mk(1, 4'hC, 32'h08070000, 0, 4'h0, 1, 12, 2, 11, 0);
    tbl[14] = mk(1, 4'hC, 32'h08070000, 0, 4'h0, 1, 12, 2, 11, 0);
    tbl[15] = mk(1, 4'hC, 32'h08070000, 1, 4'h8, 1, 13, 3, 12, 0);
    tbl[16] = mk(1, 4'h1, 32'h00000000, 0, 4'h0, 1, 13, 3, 12, 0);
    tbl[17] = mk(0, 4'h1, 32'h00000000, 0, 4'h0, 1, 13, 3, 12, 0);
    tbl[18] = mk(0, 4'h1, 32'h00000000, 0, 4'h0, 1, 13, 3, 12, 0);
    tbl[19] = mk(0, 4'h1, 32'h00000000, 1, 4'h0, 0, 13, 3, 12, 1);
    tbl[20] = mk(1, 4'h1, 32'h00000000, 1, 4'h0, 0, 13, 3, 12, 0);
    tbl[21] = mk(1, 4'h1, 32'h00000000, 1, 4'h1, 1, 5,  0, 13, 0);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    enable = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1;
    #1;
    chk("reset_ready", req_ready, 0);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_data", rsp_data, 0);
    chk("reset_id", rsp_id, 0);
    chk("reset_count", txn_count, 0);
    chk("reset_stopped", stopped, 1);
    @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      enable = tbl[i].en; req_valid = tbl[i].rv; req_data = tbl[i].rd; rsp_ready = tbl[i].rr;
      #1;
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].xr);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), rsp_valid, tbl[i].xv);
      chk($sformatf("tbl%0d_data", i), rsp_data, tbl[i].xd);
      chk($sformatf("tbl%0d_id", i), rsp_id, tbl[i].xid);
      chk($sformatf("tbl%0d_count", i), txn_count, tbl[i].xc);
      chk($sformatf("tbl%0d_stopped", i), stopped, tbl[i].xs);
    end

    // Async reset while a response is stalled.
    enable = 1'b1; req_valid = 4'hF; req_data = 32'h04030201; rsp_ready = 1'b0;
    @(posedge clk);
    #2;
    chk("stall_valid", rsp_valid, 1);
    reset = 1'b1;
    #1;
    chk("areset_valid", rsp_valid, 0);
    chk("areset_count", txn_count, 0);
    chk("areset_stopped", stopped, 1);
    chk("areset_data", rsp_data, 0);
    @(negedge clk);
    reset = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("post_reset_ready", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_valid", rsp_valid, 0);
    chk("post_reset_stopped", stopped, 0);
    #1;
    chk("post_reset_grant", req_ready, 4'h1);
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_id", rsp_id, 0);
    chk("post_reset_rdata", rsp_data, 6);
    chk("post_reset_rvalid", rsp_valid, 1);

    // Random stimulus against the reference model.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int g;
      bit can;
      logic [3:0] exp_ready;
      enable    = ($urandom_range(0, 9) != 0);
      req_valid = 4'($urandom);
      req_data  = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = model_grant(req_valid);
      can = (m_state == MRun) && (!m_valid || rsp_ready);
      exp_ready = (can && g >= 0) ? 4'(1 << g) : 4'h0;
      chk("rand_ready", req_ready, exp_ready);
      chk("rand_valid", rsp_valid, m_valid);
      chk("rand_data", rsp_data, m_data);
      chk("rand_id", rsp_id, m_id);
      chk("rand_count", txn_count, m_cnt);
      chk("rand_stopped", stopped, m_state == MStop);
      @(posedge clk);
      model_step(enable, req_valid, req_data, rsp_ready);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
